// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell reused every cycle by the serial controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one full_adder cell, LSB first,
// running carry held in a flop, results reported with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                 IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WIDTH - 1);

  state_t             state_r;
  state_t             state_nx_s;
  logic               load_s;
  logic               step_s;
  logic               last_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic               cout_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;
  logic               fa_sum_s;
  logic               fa_carry_s;

  full_adder u_fa (
    .a     (a_r[0]),
    .b     (b_r[0]),
    .cin   (carry_r),
    .sum   (fa_sum_s),
    .carry (fa_carry_s)
  );

  assign last_s = (idx_r == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and datapath control; start is only honoured in IDLE or DONE.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
          load_s     = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_nx_s = RUN;
          load_s     = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Operand shifters, carry flop, bit index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (load_s) begin
      // Subtraction is A + ~B + 1, so the inverted operand and forced carry go in here.
      a_r     <= op_a;
      b_r     <= sub ? ~op_b : op_b;
      carry_r <= sub ? 1'b1 : cin;
      sum_r   <= {WIDTH{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (step_s) begin
      sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
      a_r     <= a_r >> 1;
      b_r     <= b_r >> 1;
      carry_r <= fa_carry_s;
      idx_r   <= idx_r + IDX_W'(1);
      if (last_s) begin
        cout_r <= fa_carry_s;
        ovf_r  <= carry_r ^ fa_carry_s;
      end
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == RUN);
      done_r <= (state_nx_s == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule
